// File: rtl/pixel_matrix_readout.sv
// pixel_matrix_readout
// Latches per-pixel hits, serves the lowest-index latched pixel each cycle
// into a first-word-fall-through FIFO as a {timestamp, address} word, and
// counts pile-up cycles (a new hit landing on a still-latched pixel).
//
// Ports
//   clk        : single clock, rising edge
//   reset      : asynchronous, active-high; clears all state
//   hitin      : per-pixel hit level, sampled every edge
//   mask       : per-pixel disable (1 = disabled)
//   read       : pop request from the consumer
//   valid      : FIFO not empty; addr/ts describe the head
//   addr       : pixel index of the FIFO head
//   ts         : timestamp of the FIFO head
//   fifo_full  : FIFO holds DEPTH entries
//   busy       : OR of all pixel latches
//   pileup_cnt : saturating count of cycles with a pile-up event
module pixel_matrix_readout #(
  parameter int NPIX  = 128,
  parameter int AW    = 7,
  parameter int DEPTH = 8,
  parameter int TSW   = 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [NPIX-1:0] hitin,
  input  logic [NPIX-1:0] mask,
  input  logic            read,
  output logic            valid,
  output logic [AW-1:0]   addr,
  output logic [TSW-1:0]  ts,
  output logic            fifo_full,
  output logic            busy,
  output logic [7:0]      pileup_cnt
);

  localparam int LW = $clog2(DEPTH);
  localparam int PW = LW + 1;
  localparam int WW = TSW + AW;

  logic [NPIX-1:0] state_reg;
  logic [NPIX-1:0] state_next;
  logic [NPIX-1:0] clr;
  logic [NPIX-1:0] pile_ev;
  logic [AW-1:0]   sel;
  logic            push;
  logic            pop;

  logic [TSW-1:0]  tcnt_reg;
  logic [WW-1:0]   mem_reg [DEPTH];
  logic [PW-1:0]   wr_ptr_reg;
  logic [PW-1:0]   rd_ptr_reg;
  logic [PW-1:0]   count_reg;
  logic [PW-1:0]   count_next;
  logic [7:0]      pileup_reg;
  logic [LW-1:0]   head_idx;

  assign busy      = |state_reg;
  assign valid     = (count_reg != '0);
  assign fifo_full = (count_reg == PW'(DEPTH));
  // Fullness is the registered count, so a pop in a full cycle does not
  // free a slot for a push until the following edge.
  assign push      = busy & ~fifo_full;
  assign pop       = read & valid;

  // Priority encoder: descending scan so the lowest set index wins.
  always_comb begin
    sel = '0;
    for (int i = NPIX - 1; i >= 0; i--) begin
      if (state_reg[i]) sel = AW'(i);
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < NPIX; gi++) begin : g_pix
      assign clr[gi]        = push & (sel == AW'(gi));
      // A fresh hit re-sets the latch even if it is being served this cycle.
      assign state_next[gi] = ((state_reg[gi] & ~clr[gi]) |
                               (hitin[gi] & ~mask[gi])) & ~mask[gi];
      assign pile_ev[gi]    = hitin[gi] & ~mask[gi] & state_reg[gi] & ~clr[gi];
    end
  endgenerate

  always_comb begin
    count_next = count_reg;
    if (push && !pop)      count_next = count_reg + PW'(1);
    else if (!push && pop) count_next = count_reg - PW'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg  <= '0;
      tcnt_reg   <= '0;
      wr_ptr_reg <= '0;
      rd_ptr_reg <= '0;
      count_reg  <= '0;
      pileup_reg <= '0;
      for (int i = 0; i < DEPTH; i++) mem_reg[i] <= '0;
    end else begin
      state_reg <= state_next;
      tcnt_reg  <= tcnt_reg + TSW'(1);
      count_reg <= count_next;
      if (push) begin
        mem_reg[wr_ptr_reg[LW-1:0]] <= {tcnt_reg, sel};
        wr_ptr_reg                  <= wr_ptr_reg + PW'(1);
      end
      if (pop) rd_ptr_reg <= rd_ptr_reg + PW'(1);
      if ((|pile_ev) && (pileup_reg != 8'hFF)) pileup_reg <= pileup_reg + 8'd1;
    end
  end

  // When empty, show the slot just behind the read pointer: that is the word
  // most recently popped (or the cleared slot after reset), so addr/ts hold.
  assign head_idx   = valid ? rd_ptr_reg[LW-1:0] : (rd_ptr_reg[LW-1:0] - LW'(1));
  assign {ts, addr} = mem_reg[head_idx];
  assign pileup_cnt = pileup_reg;

endmodule

// File: tb/tb_pixel_matrix_readout.sv
module tb_pixel_matrix_readout;

  logic         clk;
  logic         reset;
  logic [127:0] hitin;
  logic [127:0] mask;
  logic         read;
  logic         valid;
  logic [6:0]   addr;
  logic [7:0]   ts;
  logic         fifo_full;
  logic         busy;
  logic [7:0]   pileup_cnt;

  int errors = 0;
  int checks = 0;

  pixel_matrix_readout #(.NPIX(128), .AW(7), .DEPTH(8), .TSW(8)) dut (
    .clk        (clk),
    .reset      (reset),
    .hitin      (hitin),
    .mask       (mask),
    .read       (read),
    .valid      (valid),
    .addr       (addr),
    .ts         (ts),
    .fifo_full  (fifo_full),
    .busy       (busy),
    .pileup_cnt (pileup_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reset released on a falling edge, so tcnt is 0 before the next rising edge.
  task automatic do_reset();
    reset = 1'b1; hitin = '0; mask = '0; read = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1; hitin = '0; mask = '0; read = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({valid, addr, ts, fifo_full, busy, pileup_cnt} !== 26'd0) begin
      $display("FAIL reset_outputs: got v=%0b a=%0d ts=%0d f=%0b b=%0b p=%0d want all 0",
               valid, addr, ts, fifo_full, busy, pileup_cnt);
      errors++;
    end
    reset = 1'b0;
  endtask

  task automatic test_single_hit();
    do_reset();
    repeat (3) @(negedge clk);
    hitin[5] = 1'b1;
    @(negedge clk);
    hitin = '0;
    checks++;
    if (busy !== 1'b1 || valid !== 1'b0) begin
      $display("FAIL single_latched: got busy=%0b valid=%0b want 1 0", busy, valid);
      errors++;
    end
    @(negedge clk);
    $display("word addr=%0d ts=%0d", addr, ts);
    checks++;
    if (valid !== 1'b1 || addr !== 7'd5 || ts !== 8'd4 || busy !== 1'b0) begin
      $display("FAIL single_word: got v=%0b a=%0d ts=%0d busy=%0b want 1 5 4 0",
               valid, addr, ts, busy);
      errors++;
    end
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (valid !== 1'b0 || addr !== 7'd5 || ts !== 8'd4 || busy !== 1'b0) begin
      $display("FAIL single_drain: got v=%0b a=%0d ts=%0d busy=%0b want 0 5 4 0",
               valid, addr, ts, busy);
      errors++;
    end
  endtask

  task automatic test_burst_order();
    int exp_a [3] = '{7, 64, 100};
    do_reset();
    hitin[100] = 1'b1; hitin[7] = 1'b1; hitin[64] = 1'b1;
    read = 1'b1;
    @(negedge clk);
    hitin = '0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      $display("word addr=%0d ts=%0d", addr, ts);
      checks++;
      if (valid !== 1'b1 || addr !== 7'(exp_a[k]) || ts !== 8'(1 + k)) begin
        $display("FAIL burst_word%0d: got v=%0b a=%0d ts=%0d want 1 %0d %0d",
                 k, valid, addr, ts, exp_a[k], 1 + k);
        errors++;
      end
    end
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL burst_empty: got v=%0b busy=%0b want 0 0", valid, busy);
      errors++;
    end
  endtask

  task automatic test_full_stall();
    do_reset();
    hitin[9:0] = '1;
    @(negedge clk);
    hitin = '0;
    repeat (7) @(negedge clk);
    checks++;
    if (fifo_full !== 1'b0) begin
      $display("FAIL full_after7: got %0b want 0", fifo_full);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (fifo_full !== 1'b1 || busy !== 1'b1 || addr !== 7'd0) begin
      $display("FAIL full_after8: got f=%0b busy=%0b a=%0d want 1 1 0", fifo_full, busy, addr);
      errors++;
    end
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (fifo_full !== 1'b0 || addr !== 7'd1) begin
      $display("FAIL full_pop1: got f=%0b a=%0d want 0 1", fifo_full, addr);
      errors++;
    end
    @(negedge clk);
    checks++;
    if (fifo_full !== 1'b1 || busy !== 1'b1) begin
      $display("FAIL full_refill: got f=%0b busy=%0b want 1 1", fifo_full, busy);
      errors++;
    end
    read = 1'b1;
    for (int k = 2; k <= 9; k++) begin
      @(negedge clk);
      $display("word addr=%0d ts=%0d", addr, ts);
      checks++;
      if (valid !== 1'b1 || addr !== 7'(k)) begin
        $display("FAIL full_drain%0d: got v=%0b a=%0d want 1 %0d", k, valid, addr, k);
        errors++;
      end
    end
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL full_empty: got v=%0b busy=%0b want 0 0", valid, busy);
      errors++;
    end
  endtask

  task automatic test_mask();
    do_reset();
    mask[3] = 1'b1; hitin[3] = 1'b1;
    @(negedge clk);
    hitin = '0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0) begin
      $display("FAIL mask_ignored: got v=%0b busy=%0b want 0 0", valid, busy);
      errors++;
    end
    mask = '0;
    hitin[7:0] = '1;
    @(negedge clk);
    hitin = '0;
    repeat (8) @(negedge clk);
    hitin[9] = 1'b1;
    @(negedge clk);
    hitin = '0;
    checks++;
    if (busy !== 1'b1 || fifo_full !== 1'b1) begin
      $display("FAIL mask_latch9: got busy=%0b f=%0b want 1 1", busy, fifo_full);
      errors++;
    end
    mask[9] = 1'b1;
    @(negedge clk);
    mask = '0;
    checks++;
    if (busy !== 1'b0) begin
      $display("FAIL mask_clear9: got busy=%0b want 0", busy);
      errors++;
    end
    read = 1'b1;
    for (int k = 0; k < 8; k++) begin
      $display("word addr=%0d ts=%0d", addr, ts);
      checks++;
      if (valid !== 1'b1 || addr !== 7'(k)) begin
        $display("FAIL mask_drain%0d: got v=%0b a=%0d want 1 %0d", k, valid, addr, k);
        errors++;
      end
      @(negedge clk);
    end
    read = 1'b0;
    @(negedge clk);
    checks++;
    if (valid !== 1'b0) begin
      $display("FAIL mask_no9: got v=%0b a=%0d want v=0", valid, addr);
      errors++;
    end
  endtask

  task automatic test_ts_wrap();
    do_reset();
    repeat (254) @(negedge clk);
    hitin[1] = 1'b1;
    @(negedge clk);
    hitin = '0; hitin[2] = 1'b1;
    @(negedge clk);
    hitin = '0;
    $display("word addr=%0d ts=%0d", addr, ts);
    checks++;
    if (valid !== 1'b1 || addr !== 7'd1 || ts !== 8'd255) begin
      $display("FAIL wrap_255: got v=%0b a=%0d ts=%0d want 1 1 255", valid, addr, ts);
      errors++;
    end
    read = 1'b1;
    @(negedge clk);
    $display("word addr=%0d ts=%0d", addr, ts);
    checks++;
    if (valid !== 1'b1 || addr !== 7'd2 || ts !== 8'd0) begin
      $display("FAIL wrap_0: got v=%0b a=%0d ts=%0d want 1 2 0", valid, addr, ts);
      errors++;
    end
    @(negedge clk);
    read = 1'b0;
  endtask

  task automatic test_pileup();
    do_reset();
    hitin[7:0] = '1;
    @(negedge clk);
    hitin = '0;
    repeat (8) @(negedge clk);
    hitin[2] = 1'b1;
    @(negedge clk);
    hitin = '0;
    checks++;
    if (pileup_cnt !== 8'd0 || busy !== 1'b1) begin
      $display("FAIL pileup_first: got p=%0d busy=%0b want 0 1", pileup_cnt, busy);
      errors++;
    end
    @(negedge clk);
    hitin[2] = 1'b1;
    @(negedge clk);
    hitin = '0;
    checks++;
    if (pileup_cnt !== 8'd1) begin
      $display("FAIL pileup_one: got %0d want 1", pileup_cnt);
      errors++;
    end
    hitin[2] = 1'b1;
    repeat (253) @(negedge clk);
    checks++;
    if (pileup_cnt !== 8'd254) begin
      $display("FAIL pileup_254: got %0d want 254", pileup_cnt);
      errors++;
    end
    repeat (47) @(negedge clk);
    hitin = '0;
    checks++;
    if (pileup_cnt !== 8'd255) begin
      $display("FAIL pileup_sat: got %0d want 255", pileup_cnt);
      errors++;
    end
  endtask

  // Continues from the full FIFO and saturated pile-up count left above.
  task automatic test_reset_mid_burst();
    hitin[10] = 1'b1; hitin[20] = 1'b1; hitin[30] = 1'b1; hitin[40] = 1'b1;
    @(negedge clk);
    hitin = '0;
    read = 1'b1;
    @(negedge clk);
    read = 1'b0;
    checks++;
    if (valid !== 1'b1 || addr !== 7'd1 || busy !== 1'b1) begin
      $display("FAIL midrst_pre: got v=%0b a=%0d busy=%0b want 1 1 1", valid, addr, busy);
      errors++;
    end
    #2;
    reset = 1'b1;
    #1;
    checks++;
    if ({valid, addr, ts, fifo_full, busy, pileup_cnt} !== 26'd0) begin
      $display("FAIL midrst_async: got v=%0b a=%0d ts=%0d f=%0b b=%0b p=%0d want all 0",
               valid, addr, ts, fifo_full, busy, pileup_cnt);
      errors++;
    end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    repeat (5) @(negedge clk);
    checks++;
    if (valid !== 1'b0 || busy !== 1'b0 || fifo_full !== 1'b0 || addr !== 7'd0) begin
      $display("FAIL midrst_after: got v=%0b busy=%0b f=%0b a=%0d want 0 0 0 0",
               valid, busy, fifo_full, addr);
      errors++;
    end
  endtask

  initial begin
    reset = 1'b1; hitin = '0; mask = '0; read = 1'b0;
    test_reset();
    test_single_hit();
    test_burst_order();
    test_full_stall();
    test_mask();
    test_ts_wrap();
    test_pileup();
    test_reset_mid_burst();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/pixel_matrix_readout.md
# pixel_matrix_readout

Parametrised, clocked successor to the 128-pixel hit-latch and priority-encoder readout. Latches hits from `NPIX` pixels, with a per-pixel mask. Each cycle, the lowest-index latched pixel is encoded into a timestamped address word and pushed into a first-word-fall-through (FWFT) FIFO, and that pixel's latch is cleared in the same cycle. Sits between the pixel array front-end and the serial/DAQ readout logic. Adds stall-free buffering, masking and pile-up counting.

## Interface
- `NPIX`, 128: number of pixels; 2..1024.
- `AW`, 7: address width; ceil(log2(`NPIX`)).
- `DEPTH`, 8: FIFO depth in entries; power of 2, ≥2.
- `TSW`, 8: timestamp width.
- `clk` input 1: single clock, rising edge.
- `reset` input 1: asynchronous, active-high; clears all state.
- `hitin` input `NPIX`: per-pixel hit level, sampled on every edge.
- `mask` input `NPIX`: 1 = pixel disabled.
- `read` input 1: pop request from the consumer.
- `valid` output 1: FIFO not empty; `addr`/`ts` are meaningful.
- `addr` output `AW`: pixel index of the FIFO head.
- `ts` output `TSW`: timestamp of the FIFO head.
- `fifo_full` output 1: FIFO holds `DEPTH` entries.
- `busy` output 1: OR of all pixel latches.
- `pileup_cnt` output 8: saturating count of cycles with at least one pile-up event.

## Operation
- **Pixel latch `state[i]`.** Next-state equation: `state_n = ((state & ~clr) | (hitin & ~mask)) & ~mask`.
  - A set always wins over a clear for the same pixel in the same cycle. The pixel re-latches.
  - Masking an already-latched pixel clears it at the next edge. No FIFO entry is produced for it.
- **Encoder.** `sel` = lowest index `i` with `state[i]=1`.
  - `push` = `busy & ~fifo_full` (registered fullness).
  - When `push` is 1: `clr` is the one-hot of `sel`; otherwise `clr` = 0.
  - Only one pixel is served per cycle.
- **Timestamp counter `tcnt`.** Free-running, width `TSW`, increments every cycle and wraps modulo 2^`TSW`. A pushed word is `{tcnt, sel}`, using the current `tcnt` value.
- **FIFO.** Read/write pointers of width log2(`DEPTH`)+1 and a count register.
  - `pop` = `read & valid`.
  - `read` while `valid=0` is ignored.
  - Push and pop in the same cycle: count is unchanged.
  - When full, `push` is suppressed even if `pop` occurs that cycle. Pixels simply stay latched, so no hit is lost.
- **Pile-up.** Event on pixel `i` = `hitin[i] & ~mask[i] & state[i] & ~clr[i]`.
  - `pileup_cnt` adds 1 per cycle in which any pixel has an event, and saturates at 255.
  - The hit merges into the existing latch.
- **Outputs.** `addr`/`ts` show the FIFO head combinationally from storage (FWFT). They hold their last value when `valid=0`.

## Timing
- **Reset values:**
  - `state` = 0; FIFO empty; `tcnt` = 0.
  - `valid` = 0, `addr` = 0, `ts` = 0 (storage cleared).
  - `fifo_full` = 0, `busy` = 0, `pileup_cnt` = 0.
- **Reset mid-operation:** reset is asynchronous and takes effect immediately. All pending hits and FIFO contents are discarded.
- **Latency, idle system:**
  - `hitin[i]` high at edge E sets `state[i]` after E.
  - Push and clear happen at E+1; `valid`=1 after E+1.
  - Total: 2 edges from sampled hit to valid output.
  - `ts` equals the `tcnt` value between E and E+1.
- **Throughput:** one word per cycle in, one word per cycle out.
  - K simultaneous hits drain in K cycles, in ascending index order, when the consumer reads every cycle.
- **Full FIFO:** the encoder stalls. The first push resumes on the edge after the first `pop` that drops the count below `DEPTH`.
- **Timestamp wrap:** `tcnt` goes 2^`TSW`−1 → 0. No flag is raised.

## Test plan
- **Single hit, idle.** Reset, then `hitin[5]`=1 for 1 cycle at `tcnt`=3 → `valid`=1 two edges later with `addr`=5, `ts`=4. `read`=1 → `valid`=0 next edge; `busy`=0 throughout after the drain.
- **Burst ordering.** Pixels 100, 7, 64 hit in the same cycle, `read` held at 1 → `addr` sequence 7, 64, 100 on consecutive cycles, with `ts` incrementing by 1.
- **Full/stall.** Defaults, `read`=0, hit pixels 0..9 together → `fifo_full`=1 after 8 pushes. Pixels 8 and 9 remain latched (`busy`=1). Pop once → pixel 8 is pushed the following edge, then `fifo_full`=1 again.
- **Mask.** `mask[3]`=1, hit pixel 3 → no word, `busy`=0. Latch pixel 9 while the FIFO is full, then set `mask[9]` → `state[9]` clears, and no word for 9 appears after draining.
- **Pile-up.** With the FIFO full, hit pixel 2 twice on separate cycles → `pileup_cnt`=1. 300 further pile-up cycles → `pileup_cnt`=255.
- **Reset mid-burst.** Hit 4 pixels and read 1 word, then assert `reset` mid-cycle → all outputs go to 0 immediately, and no stale words appear after `reset` is released.
